// File: rtl/mdu_seq_if.sv
// rtl/mdu_seq_if.sv - issue/result bundle between the EX stage and the multiply/divide unit
interface mdu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with HI/LO and busy counter
module mdu_seq #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic      clk,
  input  logic      reset,
  mdu_seq_if.slave  bus
);
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi_q, lo_q, pend_hi, pend_lo;
  logic             busy_q, done_q;

  logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
  logic               div_zero, div_ovf;
  logic [WIDTH-1:0]   sdiv_b, udiv_b, quot_s, rem_s, quot_u, rem_u;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign a_sx = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
  assign b_sx = {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
  assign a_zx = {{WIDTH{1'b0}}, bus.a};
  assign b_zx = {{WIDTH{1'b0}}, bus.b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  // Divisors are forced to 1 for the zero and overflow cases so the dividers never see them;
  // the overflow case then naturally yields quotient MIN_NEG, remainder 0.
  assign div_zero = (bus.b == '0);
  assign div_ovf  = (bus.a == MIN_NEG) && (bus.b == '1);
  assign sdiv_b   = (div_zero || div_ovf) ? ONE_W : bus.b;
  assign udiv_b   = div_zero ? ONE_W : bus.b;
  assign quot_s   = $signed(bus.a) / $signed(sdiv_b);
  assign rem_s    = $signed(bus.a) % $signed(sdiv_b);
  assign quot_u   = bus.a / udiv_b;
  assign rem_u    = bus.a % udiv_b;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (bus.op)
      3'd0: {res_hi, res_lo} = prod_s;
      3'd1: {res_hi, res_lo} = prod_u;
      3'd2: begin
        res_lo = div_zero ? '1 : quot_s;
        res_hi = div_zero ? bus.a : rem_s;
      end
      3'd3: begin
        res_lo = div_zero ? '1 : quot_u;
        res_hi = div_zero ? bus.a : rem_u;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            case (bus.op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                cnt     <= bus.op[1] ? DIV_N : MULT_N;
                busy_q  <= 1'b1;
                state   <= RUN;
              end
              3'd4:    hi_q <= bus.a;
              3'd5:    lo_q <= bus.a;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            hi_q   <= pend_hi;
            lo_q   <= pend_lo;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - directed self-checking bench for mdu_seq
module tb_mdu_seq;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  mdu_seq_if #(.WIDTH(32)) bus ();

  mdu_seq #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    tick();
    bus.start = 1'b0;
    bus.a     = 32'hDEAD_BEEF;
    bus.b     = 32'h0BAD_F00D;
  endtask

  // Samples are taken 1ns after each edge; `already` is how many busy samples were consumed.
  task automatic wait_complete(input string tag, input int already, input int exp_cyc,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc = already;
    int dones = 0;
    while (bus.busy && cyc < 40) begin
      cyc++;
      tick();
      if (bus.done) dones++;
    end
    check({tag, " busy_cycles"}, 64'(cyc), 64'(exp_cyc));
    check({tag, " done_pulses"}, 64'(dones), 64'd1);
    check({tag, " done_at_completion"}, 64'(bus.done), 64'd1);
    check({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int exp_cyc,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    issue(o, x, y);
    check({tag, " busy_after_issue"}, 64'(bus.busy), 64'd1);
    check({tag, " done_after_issue"}, 64'(bus.done), 64'd0);
    wait_complete(tag, 0, exp_cyc, exp_hi, exp_lo);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = '0;
    bus.b     = '0;

    reset = 1'b0;
    tick();
    tick();
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    reset = 1'b1;
    tick();

    run_op("mult_neg1x2", 3'd0, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    // MULTU back-to-back, with a DIV attempted while busy that must be ignored
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    tick();
    tick();
    bus.start = 1'b1;
    bus.op    = 3'd2;
    bus.a     = 32'd9;
    bus.b     = 32'd3;
    tick();
    bus.start = 1'b0;
    check("multu hi_held_while_busy", 64'(bus.hi), 64'hFFFF_FFFF);
    check("multu lo_held_while_busy", 64'(bus.lo), 64'hFFFF_FFFE);
    wait_complete("multu", 3, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    tick();
    check("multu idle_after_ignored_start", 64'(bus.busy), 64'd0);

    run_op("mult_neg3x5", 3'd0, 32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_m2", 3'd2, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu_7_0", 3'd3, 32'd7, 32'd0, 10, 32'h0000_0007, 32'hFFFF_FFFF);
    run_op("div_m5_0", 3'd2, 32'hFFFF_FFFB, 32'd0, 10, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_big", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'h0000_0001, 32'h7FFF_FFFC);
    run_op("divu_100_7", 3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14);

    issue(3'd4, 32'h1234_5678, 32'd0);
    check("mthi busy", 64'(bus.busy), 64'd0);
    check("mthi done", 64'(bus.done), 64'd0);
    check("mthi hi", 64'(bus.hi), 64'h1234_5678);
    issue(3'd5, 32'h9ABC_DEF0, 32'd0);
    check("mtlo busy", 64'(bus.busy), 64'd0);
    check("mtlo hi", 64'(bus.hi), 64'h1234_5678);
    check("mtlo lo", 64'(bus.lo), 64'h9ABC_DEF0);

    issue(3'd6, 32'h5555_5555, 32'd3);
    issue(3'd7, 32'hAAAA_AAAA, 32'd3);
    check("nop busy", 64'(bus.busy), 64'd0);
    check("nop hi", 64'(bus.hi), 64'h1234_5678);
    check("nop lo", 64'(bus.lo), 64'h9ABC_DEF0);

    // Reset during RUN cycle 4 of a DIV discards it
    issue(3'd2, 32'd100, 32'd3);
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort done", 64'(bus.done), 64'd0);
    check("abort hi", 64'(bus.hi), 64'd0);
    check("abort lo", 64'(bus.lo), 64'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done || bus.busy) dones++;
    end
    check("abort no_late_activity", 64'(dones), 64'd0);
    check("abort lo_stays", 64'(bus.lo), 64'd0);

    run_op("mult_3x4", 3'd0, 32'd3, 32'd4, 5, 32'd0, 32'd12);
    tick();
    check("final done_cleared", 64'(bus.done), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
